// File: rtl/probe_collector_if.sv
// Signal bundle between the probe collector, the debug host and the probe hook.
// The master side is the collector; the slave side is the host/hook environment.
interface probe_collector_if;
  logic        HCMD_VALID;
  logic [18:0] HCMD;
  logic        HCMD_READY;
  logic        CMDEN;
  logic [18:0] CMD;
  logic        CTIMER;
  logic [31:0] DATAUP;
  logic        DATAVALID;
  logic        DELAY;
  logic        ACK;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  DROP_CNT;

  modport master (
    input  HCMD_VALID, HCMD, DATAUP, DATAVALID, DELAY, RREADY,
    output HCMD_READY, CMDEN, CMD, CTIMER, ACK, RDATA, RVALID, DROP_CNT
  );

  modport slave (
    output HCMD_VALID, HCMD, DATAUP, DATAVALID, DELAY, RREADY,
    input  HCMD_READY, CMDEN, CMD, CTIMER, ACK, RDATA, RVALID, DROP_CNT
  );
endinterface

// File: rtl/probe_collector.sv
// Host-side end of the probe hook: command strobe, CTIMER tick, ACKed capture into a FWFT FIFO.
// Optional macro PROBE_COLLECTOR_DROP_ON_FULL_EN: ACK and discard words when the FIFO is full.
module probe_collector #(
  parameter int FIFO_DEPTH = 8,
  parameter int CTIMER_DIV = 1024
) (
  input  logic               UCLK,
  input  logic               URST_N,
  probe_collector_if.master  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CTIMER_DIV);
  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    ACKST    = 1'b1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(CTIMER_DIV - 1);

  logic          cmden_q, cmden_d;
  logic [18:0]   cmd_q, cmd_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ctimer_q, ctimer_d;
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem [FIFO_DEPTH];
  logic          hcmd_ready, accept, full, push, pop;
`ifdef PROBE_COLLECTOR_DROP_ON_FULL_EN
  logic [7:0]    drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    hcmd_ready = !bus.DELAY && !cmden_q;
    accept     = bus.HCMD_VALID && hcmd_ready;
    cmden_d    = accept;
    cmd_d      = accept ? bus.HCMD : cmd_q;

    ctimer_d   = (tmr_q == TMR_LAST);
    tmr_d      = ctimer_d ? '0 : tmr_q + 1'b1;
  end

  // "full" uses the registered count, so a same-edge pop never frees a slot for a push.
  always_comb begin
    full    = (count_q == FULL_CNT);
    pop     = bus.RREADY && (count_q != '0);
    push    = 1'b0;
    state_d = state_q;
`ifdef PROBE_COLLECTOR_DROP_ON_FULL_EN
    drop_cnt_d = drop_cnt_q;
`endif
    if (state_q == IDLE) begin
      if (bus.DATAVALID) begin
        if (!full) begin
          push    = 1'b1;
          state_d = ACKST;
        end
`ifdef PROBE_COLLECTOR_DROP_ON_FULL_EN
        else begin
          state_d = ACKST;
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
`endif
      end
    end else begin
      state_d = IDLE;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge UCLK or negedge URST_N) begin
    if (!URST_N) begin
      cmden_q  <= 1'b0;
      cmd_q    <= '0;
      tmr_q    <= '0;
      ctimer_q <= 1'b0;
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cmden_q  <= cmden_d;
      cmd_q    <= cmd_d;
      tmr_q    <= tmr_d;
      ctimer_q <= ctimer_d;
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; validity comes from count_q.
  always_ff @(posedge UCLK) begin
    if (push) mem[wr_ptr_q] <= bus.DATAUP;
  end

`ifdef PROBE_COLLECTOR_DROP_ON_FULL_EN
  always_ff @(posedge UCLK or negedge URST_N) begin
    if (!URST_N) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end
  assign bus.DROP_CNT = drop_cnt_q;
`else
  assign bus.DROP_CNT = 8'd0;
`endif

  assign bus.HCMD_READY = hcmd_ready;
  assign bus.CMDEN      = cmden_q;
  assign bus.CMD        = cmd_q;
  assign bus.CTIMER     = ctimer_q;
  assign bus.ACK        = (state_q == ACKST);
  assign bus.RVALID     = (count_q != '0);
  assign bus.RDATA      = (count_q != '0) ? mem[rd_ptr_q] : 32'd0;
endmodule

// File: tb/tb_probe_collector.sv
// Directed bench for probe_collector (FIFO_DEPTH=8, CTIMER_DIV=4).
// Follows PROBE_COLLECTOR_DROP_ON_FULL_EN when the build defines it.
module tb_probe_collector;
  logic UCLK;
  logic URST_N;
  int   n_cmp = 0;
  int   n_bad = 0;

  probe_collector_if bus();

  probe_collector #(.FIFO_DEPTH(8), .CTIMER_DIV(4)) dut (
    .UCLK   (UCLK),
    .URST_N (URST_N),
    .bus    (bus)
  );

  initial begin
    UCLK = 1'b0;
    forever #5 UCLK = ~UCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UCLK);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmden"},  32'(bus.CMDEN),    32'd0);
    chk({tag, "_cmd"},    32'(bus.CMD),      32'd0);
    chk({tag, "_ctimer"}, 32'(bus.CTIMER),   32'd0);
    chk({tag, "_ack"},    32'(bus.ACK),      32'd0);
    chk({tag, "_rvalid"}, 32'(bus.RVALID),   32'd0);
    chk({tag, "_rdata"},  bus.RDATA,         32'd0);
    chk({tag, "_drop"},   32'(bus.DROP_CNT), 32'd0);
  endtask

  initial begin
    URST_N = 1'b0;
    bus.HCMD_VALID = 1'b0;
    bus.HCMD       = '0;
    bus.DATAUP     = '0;
    bus.DATAVALID  = 1'b0;
    bus.DELAY      = 1'b0;
    bus.RREADY     = 1'b0;
    tick();
    tick();
    chk_idle_outputs("rst");

    // CTIMER: first pulse after the 4th edge following release, then every 4 edges
    URST_N = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("ctimer_%0d", i), 32'(bus.CTIMER), ((i % 4) == 0) ? 32'd1 : 32'd0);
    end

    // Command path
    bus.HCMD_VALID = 1'b1;
    bus.HCMD       = 19'h1A5;
    #1;
    chk("cmd_ready_pre", 32'(bus.HCMD_READY), 32'd1);
    tick();
    chk("cmd_strobe", 32'(bus.CMDEN), 32'd1);
    chk("cmd_val", 32'(bus.CMD), 32'h1A5);
    chk("cmd_ready_busy", 32'(bus.HCMD_READY), 32'd0);
    bus.HCMD_VALID = 1'b0;
    tick();
    chk("cmd_strobe_end", 32'(bus.CMDEN), 32'd0);
    chk("cmd_hold", 32'(bus.CMD), 32'h1A5);
    bus.DELAY      = 1'b1;
    bus.HCMD_VALID = 1'b1;
    bus.HCMD       = 19'h2B;
    tick();
    chk("cmd_delay1", 32'(bus.CMDEN), 32'd0);
    tick();
    chk("cmd_delay2", 32'(bus.CMDEN), 32'd0);
    chk("cmd_delay_hold", 32'(bus.CMD), 32'h1A5);
    bus.DELAY = 1'b0;
    tick();
    chk("cmd_after_delay", 32'(bus.CMDEN), 32'd1);
    chk("cmd_after_delay_val", 32'(bus.CMD), 32'h2B);
    tick();
    chk("cmd_gap", 32'(bus.CMDEN), 32'd0);
    tick();
    chk("cmd_again", 32'(bus.CMDEN), 32'd1);
    bus.HCMD_VALID = 1'b0;
    tick();

    // Capture stream with the reader always ready
    bus.RREADY = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.DATAUP    = 32'(k * 32'h11);
      bus.DATAVALID = 1'b1;
      tick();
      chk($sformatf("cap_ack_%0d", k), 32'(bus.ACK), 32'd1);
      chk($sformatf("cap_rvalid_%0d", k), 32'(bus.RVALID), 32'd1);
      chk($sformatf("cap_rdata_%0d", k), bus.RDATA, 32'(k * 32'h11));
      if (k == 3) bus.DATAVALID = 1'b0;
      tick();
      chk($sformatf("cap_gap_ack_%0d", k), 32'(bus.ACK), 32'd0);
      chk($sformatf("cap_gap_rvalid_%0d", k), 32'(bus.RVALID), 32'd0);
    end
    bus.RREADY = 1'b0;

    // Fill the FIFO with the reader stalled
    for (int k = 0; k < 8; k++) begin
      bus.DATAUP    = 32'h40 + 32'(k);
      bus.DATAVALID = 1'b1;
      tick();
      chk($sformatf("fill_ack_%0d", k), 32'(bus.ACK), 32'd1);
      tick();
      chk($sformatf("fill_gap_%0d", k), 32'(bus.ACK), 32'd0);
    end
    chk("full_head", bus.RDATA, 32'h40);
    bus.DATAUP = 32'h48;
`ifdef PROBE_COLLECTOR_DROP_ON_FULL_EN
    tick();
    chk("drop_ack9", 32'(bus.ACK), 32'd1);
    bus.DATAUP = 32'h49;
    tick();
    chk("drop_gap", 32'(bus.ACK), 32'd0);
    tick();
    chk("drop_ack10", 32'(bus.ACK), 32'd1);
    bus.DATAVALID = 1'b0;
    tick();
    chk("drop_cnt2", 32'(bus.DROP_CNT), 32'd2);
    bus.DATAVALID = 1'b1;
    for (int i = 0; i < 600; i++) tick();
    chk("drop_sat", 32'(bus.DROP_CNT), 32'd255);
    bus.DATAVALID = 1'b0;
    tick();
    tick();
    bus.RREADY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_v_%0d", k), 32'(bus.RVALID), 32'd1);
      chk($sformatf("drain_d_%0d", k), bus.RDATA, 32'h40 + 32'(k));
      tick();
    end
`else
    tick();
    chk("stall_ack1", 32'(bus.ACK), 32'd0);
    tick();
    chk("stall_ack2", 32'(bus.ACK), 32'd0);
    bus.RREADY = 1'b1;
    tick();
    chk("pop_edge_ack", 32'(bus.ACK), 32'd0);
    bus.RREADY = 1'b0;
    chk("pop_head", bus.RDATA, 32'h41);
    tick();
    chk("word9_ack", 32'(bus.ACK), 32'd1);
    bus.DATAUP = 32'h49;
    tick();
    chk("word10_gap", 32'(bus.ACK), 32'd0);
    tick();
    chk("word10_stall", 32'(bus.ACK), 32'd0);
    chk("no_drop_cnt", 32'(bus.DROP_CNT), 32'd0);
    bus.DATAVALID = 1'b0;
    bus.RREADY    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_v_%0d", k), 32'(bus.RVALID), 32'd1);
      chk($sformatf("drain_d_%0d", k), bus.RDATA, 32'h40 + 32'(k));
      tick();
    end
`endif
    chk("drain_empty", 32'(bus.RVALID), 32'd0);
    bus.RREADY = 1'b0;

    // Asynchronous reset in the middle of an ACK with a command strobe in flight
    bus.DATAUP     = 32'h77;
    bus.DATAVALID  = 1'b1;
    bus.HCMD_VALID = 1'b1;
    bus.HCMD       = 19'h3C;
    tick();
    chk("pre_rst_ack", 32'(bus.ACK), 32'd1);
    chk("pre_rst_cmden", 32'(bus.CMDEN), 32'd1);
    chk("pre_rst_rvalid", 32'(bus.RVALID), 32'd1);
    #1;
    URST_N = 1'b0;
    #1;
    chk("async_ack", 32'(bus.ACK), 32'd0);
    chk("async_cmden", 32'(bus.CMDEN), 32'd0);
    chk("async_rvalid", 32'(bus.RVALID), 32'd0);
    chk("async_cmd", 32'(bus.CMD), 32'd0);
    bus.DATAVALID  = 1'b0;
    bus.HCMD_VALID = 1'b0;
    tick();
    tick();
    URST_N = 1'b1;
    tick();
    chk_idle_outputs("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
